div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one pipelined divider (8-bit dividend/divisor, 16-bit result, divide-by-zero flag on tuser) between N_REQ requesters in the color-detect pipeline. Each request is granted round-robin, issued to the divider with a requester tag queued in order, and the result is returned to the originating requester when the divider's output valid fires. The block also sequences the divider's active-low reset so the IP is never driven while held in reset.

## Interface
- N_REQ, 4: number of requesters (2..8).
- MAX_OUT, 16: maximum outstanding divides; tag FIFO depth (power of two, ≥ divider latency + 1 for full throughput).
- RST_HOLD, 3: cycles div_aresetn stays low after rst deasserts (≥2 per divider IP requirement).
- clk  in  1  single clock for block and divider.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant; transfer when valid&ready.
- req_dividend  in  8*N_REQ  dividend, requester i at [8i+7:8i].
- req_divisor  in  8*N_REQ  divisor, same packing.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse to owning requester.
- rsp_data  out  16  divider result, passed through unmodified ([15:8] quotient, [7:0] remainder).
- rsp_dbz  out  1  divide-by-zero flag for this response.
- div_aresetn  out  1  divider reset, active-low.
- div_dividend_tdata / div_divisor_tdata  out  8 each  operands to divider.
- div_dividend_tvalid / div_divisor_tvalid  out  1 each  always driven identically.
- div_dout_tdata  in  16;  div_dout_tvalid  in  1;  div_dout_tuser  in  1 (dbz).
- orphan_err  out  1  sticky: result arrived with no outstanding tag.

## Operation
- FSM states: INIT, RUN. rst forces INIT; INIT counts RST_HOLD cycles with div_aresetn=0, then div_aresetn=1 and → RUN. RUN → INIT only via rst.
- Arbitration (RUN only): eligible when outstanding count < MAX_OUT. Grant lowest index ≥ rr_ptr with req_valid set, wrapping modulo N_REQ. req_ready is combinational, at most one bit high, only for a requester with req_valid high. After a grant to i, rr_ptr ← (i+1) mod N_REQ; no grant leaves rr_ptr unchanged.
- Issue: on handshake, operands registered to div_*_tdata, both tvalids high next cycle for exactly one cycle; index pushed into tag FIFO the same cycle. Divider has no backpressure; one issue per cycle max.
- Return: on div_dout_tvalid in RUN, pop tag t; next cycle rsp_valid[t]=1, rsp_data=div_dout_tdata, rsp_dbz=div_dout_tuser. Responses are in issue order. No backpressure on responses.
- Outstanding count: +1 on handshake, −1 on div_dout_tvalid pop; simultaneous → unchanged. Width clog2(MAX_OUT)+1.
- dout_tvalid with count 0 in RUN: no response, no pop, orphan_err←1 (cleared only by rst). dout_tvalid in INIT ignored, no error.
- Operands passed as unsigned 8-bit; signedness is a divider configuration, not interpreted here.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_dbz=0, div_*_tdata=0, div_*_tvalid=0, div_aresetn=0, orphan_err=0, rr_ptr=0, count=0, tag FIFO empty, state INIT.
- First possible grant: cycle RST_HOLD+1 after rst deasserts.
- Request-to-divider latency: 1 cycle. Divider-result-to-response latency: 1 cycle. End-to-end: divider latency + 2.
- Full: count==MAX_OUT drops all req_ready that cycle; a pop in the same cycle does not re-enable grant until the following cycle (ready depends on registered count only).
- rst mid-operation: outstanding tags dropped, div_aresetn low, pending rsp_valid cleared immediately; in-flight divider results lost (divider also reset).
- Continuous requests from all requesters: one grant per cycle, rotating 0,1,…,N_REQ−1,0.

## Test plan
- Single request req0 5/2 after INIT → req_ready[0] one cycle, div tvalids next cycle with 5/2, rsp_valid[0] pulse, rsp_data={8'd2,8'd1}, rsp_dbz=0.
- req1 3/0 → rsp_valid[1], rsp_dbz=1; then 1/1 from req1 → rsp_dbz=0, quotient 1.
- All four requesters valid same cycle (1/1, 1/2, 1/3, 2/10) → grants 0,1,2,3 on consecutive cycles, responses in same order with correct owner bits.
- req0 and req2 held valid continuously from rr_ptr=0 → grants alternate 0,2,0,2; never two consecutive to one requester.
- Divider model withholds results, 20 requests queued → exactly 16 grants then req_ready=0; release one result → one further grant the cycle after the pop.
- rst asserted with 5 outstanding → all outputs to reset values, div_aresetn low for RST_HOLD cycles after release, no rsp_valid; injected dout_tvalid with count 0 in RUN → orphan_err=1 and stays set.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Requester-side handshake and divider-side AXI-stream signals for div_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface div_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_dividend;
  logic [8*N_REQ-1:0] req_divisor;
  logic [N_REQ-1:0]   rsp_valid;
  logic [15:0]        rsp_data;
  logic               rsp_dbz;
  logic               div_aresetn;
  logic [7:0]         div_dividend_tdata;
  logic [7:0]         div_divisor_tdata;
  logic               div_dividend_tvalid;
  logic               div_divisor_tvalid;
  logic [15:0]        div_dout_tdata;
  logic               div_dout_tvalid;
  logic               div_dout_tuser;
  logic               orphan_err;

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    input  div_dout_tdata, div_dout_tvalid, div_dout_tuser,
    output req_ready, rsp_valid, rsp_data, rsp_dbz,
    output div_aresetn, div_dividend_tdata, div_divisor_tdata,
    output div_dividend_tvalid, div_divisor_tvalid, orphan_err
  );

  modport master (
    output req_valid, req_dividend, req_divisor,
    output div_dout_tdata, div_dout_tvalid, div_dout_tuser,
    input  req_ready, rsp_valid, rsp_data, rsp_dbz,
    input  div_aresetn, div_dividend_tdata, div_divisor_tdata,
    input  div_dividend_tvalid, div_divisor_tvalid, orphan_err
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one pipelined divider among N_REQ requesters, with an
// in-order tag FIFO routing results back and sequencing of the divider reset.
module div_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_OUT  = 16,
  parameter int unsigned RST_HOLD = 3
) (
  input logic          clk,
  input logic          rst,
  div_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned AW    = $clog2(MAX_OUT);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned HW    = $clog2(RST_HOLD + 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             run;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_q, rr_d, gnt_idx;
  logic             gnt, pop, orphan;
  int unsigned      cand;
  logic [AW-1:0]    wr_q, rd_q;
  logic [IDX_W-1:0] tag_mem [MAX_OUT];
  logic [7:0]       dvd [N_REQ];
  logic [7:0]       dvs [N_REQ];
  logic [7:0]       dvd_q, dvs_q;
  logic             tvalid_q;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_data_q;
  logic             rsp_dbz_q, orphan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (state_q == INIT) begin
      if (hold_q == HW'(RST_HOLD - 1)) state_d = RUN;
      else                             hold_d  = hold_q + 1'b1;
    end
  end

  assign run = (state_q == RUN);

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd[g] = bus.req_dividend[8*g +: 8];
    assign dvs[g] = bus.req_divisor[8*g +: 8];
  end

  // Scan from rr_q upward with wrap; ready uses only the registered count.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_q) + k) % N_REQ;
      if (!gnt && run && (cnt_q < CW'(MAX_OUT)) && bus.req_valid[IDX_W'(cand)]) begin
        gnt     = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt) rr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign pop    = run && bus.div_dout_tvalid && (cnt_q != '0);
  assign orphan = run && bus.div_dout_tvalid && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!gnt && pop) cnt_d = cnt_q - 1'b1;
  end

  always_comb begin
    rsp_valid_d = '0;
    if (pop) rsp_valid_d[tag_mem[rd_q]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (gnt) tag_mem[wr_q] <= gnt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      tvalid_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_dbz_q   <= 1'b0;
      orphan_q    <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      tvalid_q    <= gnt;
      rsp_valid_q <= rsp_valid_d;
      if (gnt) begin
        wr_q  <= wr_q + 1'b1;
        dvd_q <= dvd[gnt_idx];
        dvs_q <= dvs[gnt_idx];
      end
      if (pop) begin
        rd_q       <= rd_q + 1'b1;
        rsp_data_q <= bus.div_dout_tdata;
        rsp_dbz_q  <= bus.div_dout_tuser;
      end
      if (orphan) orphan_q <= 1'b1;
    end
  end

  assign bus.div_aresetn         = run;
  assign bus.div_dividend_tdata  = dvd_q;
  assign bus.div_divisor_tdata   = dvs_q;
  assign bus.div_dividend_tvalid = tvalid_q;
  assign bus.div_divisor_tvalid  = tvalid_q;
  assign bus.rsp_valid           = rsp_valid_q;
  assign bus.rsp_data            = rsp_data_q;
  assign bus.rsp_dbz             = rsp_dbz_q;
  assign bus.orphan_err          = orphan_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a behavioural divider with hold/inject
// controls, per-requester operation queues and an in-order response scoreboard.
module tb_div_arbiter;
  localparam int NR   = 4;
  localparam int MAXO = 16;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if #(.N_REQ(NR)) bus ();

  div_arbiter #(.N_REQ(NR), .MAX_OUT(MAXO), .RST_HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int owner; logic [15:0] data; logic dbz; } exp_t;
  typedef struct { int due; logic [15:0] data; logic dbz; } mdl_t;

  exp_t        sb[$];
  mdl_t        mq[$];
  logic [15:0] opq [NR][$];
  int          gnt_log[$];
  int          gcyc_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_gnt = -1;
  logic        hold = 1'b0;
  int          rel_allow = 0, rel_done = 0;
  int          inj_allow = 0, inj_done = 0;
  int          mcyc = 0;

  // Reference divider: {dbz, quotient, remainder}; divide-by-zero returns FF/dividend.
  function automatic logic [16:0] div_ref(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    return {1'b0, a / b, a % b};
  endfunction

  // Divider model: one-step latency, flushed while held in reset.
  initial begin
    logic [16:0] r;
    mdl_t        d;
    bus.div_dout_tvalid = 1'b0;
    bus.div_dout_tdata  = '0;
    bus.div_dout_tuser  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.div_dout_tvalid = 1'b0;
      bus.div_dout_tuser  = 1'b0;
      if (!bus.div_aresetn) mq.delete();
      else if (bus.div_dividend_tvalid) begin
        r = div_ref(bus.div_dividend_tdata, bus.div_divisor_tdata);
        mq.push_back('{mcyc + 1, r[15:0], r[16]});
      end
      if (inj_done < inj_allow) begin
        inj_done++;
        bus.div_dout_tvalid = 1'b1;
        bus.div_dout_tdata  = 16'hBEEF;
      end else if (mq.size() > 0 && mq[0].due <= mcyc && (!hold || rel_done < rel_allow)) begin
        d = mq.pop_front();
        rel_done++;
        bus.div_dout_tvalid = 1'b1;
        bus.div_dout_tdata  = d.data;
        bus.div_dout_tuser  = d.dbz;
      end
      mcyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit idle();
    for (int i = 0; i < NR; i++) if (opq[i].size() > 0) return 1'b0;
    return sb.size() == 0;
  endfunction

  // Called at a falling edge: drive requests, then sample 1ns later.
  task automatic drive_sample();
    exp_t        e;
    logic [16:0] r;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = (opq[i].size() > 0);
      if (opq[i].size() > 0) begin
        bus.req_dividend[8*i +: 8] = opq[i][0][15:8];
        bus.req_divisor[8*i +: 8]  = opq[i][0][7:0];
      end
    end
    #1;
    if (bus.rsp_valid !== '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << e.owner);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(e.dbz));
      end
    end
    chk("ready_legal", 32'($onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)), 1);
    last_gnt = -1;
    for (int i = 0; i < NR; i++) if (bus.req_ready[i] === 1'b1) last_gnt = i;
    if (last_gnt >= 0 && opq[last_gnt].size() > 0) begin
      r = div_ref(opq[last_gnt][0][15:8], opq[last_gnt][0][7:0]);
      sb.push_back('{last_gnt, r[15:0], r[16]});
      void'(opq[last_gnt].pop_front());
      gnt_log.push_back(last_gnt);
      gcyc_log.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic cyc_step();
    drive_sample();
    adv();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!idle() && n < budget) begin
      cyc_step();
      n++;
    end
    chk("drain_done", 32'(idle()), 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_dbz", 32'(bus.rsp_dbz), 0);
    chk("rst_dividend", 32'(bus.div_dividend_tdata), 0);
    chk("rst_divisor", 32'(bus.div_divisor_tdata), 0);
    chk("rst_tvalids", 32'({bus.div_dividend_tvalid, bus.div_divisor_tvalid}), 0);
    chk("rst_aresetn", 32'(bus.div_aresetn), 0);
    chk("rst_orphan", 32'(bus.orphan_err), 0);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      drive_sample();
      chk("aresetn_hold", 32'(bus.div_aresetn), 0);
      chk("init_no_ready", 32'(bus.req_ready), 0);
      adv();
    end
    drive_sample();
    chk("aresetn_up", 32'(bus.div_aresetn), 1);
  endtask

  initial begin
    bus.req_valid    = '1;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals();
    @(negedge clk);

    // Single request 5/2 queued during INIT; granted on the first RUN cycle.
    opq[0].push_back({8'd5, 8'd2});
    release_reset();
    chk("first_grant", last_gnt, 0);
    adv();
    drive_sample();
    chk("issue_tvalid", 32'({bus.div_dividend_tvalid, bus.div_divisor_tvalid}), 32'b11);
    chk("issue_dividend", 32'(bus.div_dividend_tdata), 5);
    chk("issue_divisor", 32'(bus.div_divisor_tdata), 2);
    adv();
    drive_sample();
    chk("issue_one_cycle", 32'({bus.div_dividend_tvalid, bus.div_divisor_tvalid}), 0);
    adv();
    drain(50);

    // Divide by zero, then a normal 1/1 from the same requester.
    opq[1].push_back({8'd3, 8'd0});
    opq[1].push_back({8'd1, 8'd1});
    drain(50);

    // Grant to 3 wraps the pointer to 0, then all four compete.
    opq[3].push_back({8'd200, 8'd7});
    drain(50);
    gnt_log.delete();
    gcyc_log.delete();
    opq[0].push_back({8'd1, 8'd1});
    opq[1].push_back({8'd1, 8'd2});
    opq[2].push_back({8'd1, 8'd3});
    opq[3].push_back({8'd2, 8'd10});
    drain(60);
    chk("all4_count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
      chk("all4_order", gnt_log[k], k);
      chk("all4_consec", gcyc_log[k] - gcyc_log[0], k);
    end

    // Requesters 0 and 2 held valid: grants must alternate.
    gnt_log.delete();
    for (int k = 0; k < 4; k++) begin
      opq[0].push_back({8'(10 + k), 8'd3});
      opq[2].push_back({8'(20 + k), 8'd4});
    end
    drain(80);
    chk("alt_count", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("alt_order", gnt_log[k], (k % 2) * 2);

    // Results withheld: exactly MAX_OUT grants, then one more after a single pop.
    hold = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 5; k++) opq[i].push_back({8'(30 + 5 * i + k), 8'(k + 1)});
    repeat (23) cyc_step();
    drive_sample();
    chk("full_grants", gnt_log.size(), MAXO);
    chk("full_ready", 32'(bus.req_ready), 0);
    rel_allow = rel_done + 1;
    adv();
    drive_sample();
    chk("full_pop_cycle_no_grant", last_gnt, -1);
    adv();
    drive_sample();
    chk("full_grant_after_pop", 32'(last_gnt >= 0), 1);
    hold = 1'b0;
    adv();
    drain(300);

    // Reset with five divides outstanding.
    hold = 1'b1;
    gnt_log.delete();
    for (int k = 0; k < 5; k++) opq[1].push_back({8'(50 + k), 8'd6});
    repeat (8) cyc_step();
    chk("prerst_grants", gnt_log.size(), 5);
    rst = 1'b1;
    bus.req_valid = '1;
    #1 check_reset_vals();
    sb.delete();
    hold = 1'b0;
    @(negedge clk);
    inj_allow = inj_done + 1;
    release_reset();
    adv();
    repeat (6) cyc_step();
    drive_sample();
    chk("orphan_init_ignored", 32'(bus.orphan_err), 0);

    // Result with nothing outstanding in RUN.
    inj_allow = inj_done + 1;
    adv();
    drive_sample();
    adv();
    drive_sample();
    chk("orphan_set", 32'(bus.orphan_err), 1);
    adv();
    repeat (5) cyc_step();
    drive_sample();
    chk("orphan_sticky", 32'(bus.orphan_err), 1);
    chk("end_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
